// File: rtl/cpu_btb_pkg.sv
// Shared constants and the 2-bit saturating direction counter helper for the
// set-associative branch target buffer.
package cpu_btb_pkg;

  localparam int CTR_W = 2;

  localparam logic [CTR_W-1:0] STRONG_NT = 2'd0;
  localparam logic [CTR_W-1:0] WEAK_NT   = 2'd1;
  localparam logic [CTR_W-1:0] WEAK_T    = 2'd2;
  localparam logic [CTR_W-1:0] STRONG_T  = 2'd3;

  // One training step: count up on taken, down on not-taken, clamp at both ends.
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                input logic             taken);
    logic [CTR_W-1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != STRONG_T)) begin
      nxt = ctr + 1'b1;
    end else if (!taken && (ctr != STRONG_NT)) begin
      nxt = ctr - 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_btb_way.sv
// One way of the BTB: per-set valid bit, tag, target and (optionally) direction
// counter. Two read ports: one for the lookup PC, one for the update PC.
// Writes come from a one-hot per-set enable supplied by the parent.
// Optional feature macro: CPU_BTB_COUNTER_EN (adds the per-entry counter).
module cpu_btb_way
  import cpu_btb_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int SET_W = 6,
  parameter int TAG_W = 24,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [SETS-1:0]   wr_en_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [XLEN-1:0]   wr_target_i,
`ifdef CPU_BTB_COUNTER_EN
  input  logic              wr_alloc_i,
  input  logic              wr_taken_i,
  output logic [CTR_W-1:0]  rd_ctr_o,
`endif
  input  logic [SET_W-1:0]  rd_set_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [XLEN-1:0]   rd_target_o,
  input  logic [SET_W-1:0]  up_set_i,
  output logic              up_valid_o,
  output logic [TAG_W-1:0]  up_tag_o
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q    [SETS];
  logic [XLEN-1:0]  target_q [SETS];

  // Valid bits: cleared by reset or flush, set by any write to the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_q | wr_en_i;
    end
  end

  // Tag and target payload: no reset, only meaningful while valid.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SETS; s++) begin
      if (wr_en_i[s]) begin
        tag_q[s]    <= wr_tag_i;
        target_q[s] <= wr_target_i;
      end
    end
  end

`ifdef CPU_BTB_COUNTER_EN
  logic [CTR_W-1:0] ctr_q [SETS];

  // Direction counters: fresh entries start weakly taken, hits train the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) ctr_q[s] <= WEAK_NT;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        if (wr_en_i[s]) begin
          ctr_q[s] <= wr_alloc_i ? WEAK_T : ctr_step(ctr_q[s], wr_taken_i);
        end
      end
    end
  end

  assign rd_ctr_o = ctr_q[rd_set_i];
`endif

  assign rd_valid_o  = valid_q[rd_set_i];
  assign rd_tag_o    = tag_q[rd_set_i];
  assign rd_target_o = target_q[rd_set_i];
  assign up_valid_o  = valid_q[up_set_i];
  assign up_tag_o    = tag_q[up_set_i];

endmodule

// File: rtl/cpu_btb_set_assoc.sv
// Set-associative branch target buffer. Lookup is purely combinational on the
// registered state, so a same-cycle update to the same set is not yet visible.
// Updates train a hitting way or allocate (taken only) into the lowest invalid
// way, falling back to a per-set round-robin victim. Flush wins over update.
// Optional feature macro: CPU_BTB_COUNTER_EN (2-bit direction counters).
module cpu_btb_set_assoc
  import cpu_btb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int SET_WIDTH = 6,
  parameter int WAYS      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            update,
  input  logic [XLEN-1:0] update_addr,
  input  logic [XLEN-1:0] update_target_addr,
  input  logic            update_taken,
  input  logic [XLEN-1:0] branch_addr,
  output logic            branch_hit,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target_addr
);

  localparam int SETS  = 1 << SET_WIDTH;
  localparam int TAG_W = XLEN - SET_WIDTH - 2;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [SET_WIDTH-1:0] lu_set, up_set;
  logic [TAG_W-1:0]     lu_tag, up_tag;
  logic                 unused_addr_bits;

  assign lu_set = branch_addr[SET_WIDTH+1:2];
  assign lu_tag = branch_addr[XLEN-1:SET_WIDTH+2];
  assign up_set = update_addr[SET_WIDTH+1:2];
  assign up_tag = update_addr[XLEN-1:SET_WIDTH+2];
  // Byte offset within the instruction word never participates.
  assign unused_addr_bits = ^{branch_addr[1:0], update_addr[1:0]};

  logic [WAYS-1:0]  lu_valid, up_valid;
  logic [TAG_W-1:0] lu_tag_w    [WAYS];
  logic [TAG_W-1:0] up_tag_w    [WAYS];
  logic [XLEN-1:0]  lu_target_w [WAYS];
  logic [SETS-1:0]  way_wen     [WAYS];
`ifdef CPU_BTB_COUNTER_EN
  logic [CTR_W-1:0] lu_ctr_w    [WAYS];
  logic [CTR_W-1:0] lu_ctr;
`endif

  logic [PTR_W-1:0] rr_q [SETS];

  logic             up_hit, has_inv, do_write, evict;
  logic [PTR_W-1:0] hit_idx, inv_idx, victim, wr_way;

  // Update side: find a hitting way, the lowest invalid way, and the write target.
  always_comb begin
    up_hit  = 1'b0;
    hit_idx = '0;
    has_inv = 1'b0;
    inv_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!up_valid[w]) begin
        has_inv = 1'b1;
        inv_idx = PTR_W'(w);
      end
      if (up_valid[w] && (up_tag_w[w] == up_tag)) begin
        up_hit  = 1'b1;
        hit_idx = PTR_W'(w);
      end
    end
    victim   = has_inv ? inv_idx : rr_q[up_set];
    do_write = update && !flush && (up_hit || update_taken);
    wr_way   = up_hit ? hit_idx : victim;
    evict    = do_write && !up_hit && !has_inv;
  end

  // One-hot per-set write enable steered to the selected way.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      way_wen[w] = '0;
      if (do_write && (wr_way == PTR_W'(w))) way_wen[w][up_set] = 1'b1;
    end
  end

  // Round-robin victim pointers: advance only when a valid entry is displaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (evict) begin
      rr_q[up_set] <= (rr_q[up_set] == PTR_W'(WAYS - 1)) ? '0 : rr_q[up_set] + 1'b1;
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cpu_btb_way #(
      .SETS (SETS),
      .SET_W(SET_WIDTH),
      .TAG_W(TAG_W),
      .XLEN (XLEN)
    ) u_way (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .wr_en_i    (way_wen[g]),
      .wr_tag_i   (up_tag),
      .wr_target_i(update_target_addr),
`ifdef CPU_BTB_COUNTER_EN
      .wr_alloc_i (!up_hit),
      .wr_taken_i (update_taken),
      .rd_ctr_o   (lu_ctr_w[g]),
`endif
      .rd_set_i   (lu_set),
      .rd_valid_o (lu_valid[g]),
      .rd_tag_o   (lu_tag_w[g]),
      .rd_target_o(lu_target_w[g]),
      .up_set_i   (up_set),
      .up_valid_o (up_valid[g]),
      .up_tag_o   (up_tag_w[g])
    );
  end

  // Lookup: OR-merge the matching way (at most one matches); all zeros on miss.
  always_comb begin
    branch_hit         = 1'b0;
    branch_target_addr = '0;
`ifdef CPU_BTB_COUNTER_EN
    lu_ctr             = '0;
`endif
    for (int w = 0; w < WAYS; w++) begin
      if (lu_valid[w] && (lu_tag_w[w] == lu_tag)) begin
        branch_hit         = 1'b1;
        branch_target_addr = branch_target_addr | lu_target_w[w];
`ifdef CPU_BTB_COUNTER_EN
        lu_ctr             = lu_ctr | lu_ctr_w[w];
`endif
      end
    end
`ifdef CPU_BTB_COUNTER_EN
    branch_taken = branch_hit & lu_ctr[1];
`else
    branch_taken = branch_hit;
`endif
  end

endmodule

// File: tb/tb_cpu_btb_set_assoc.sv
// Bench for cpu_btb_set_assoc: directed scenarios followed by a randomized run
// against a small reference model. Lookup expectations are queued when the
// lookup address is driven and compared on the following falling edge.
module tb_cpu_btb_set_assoc;

  localparam int XLEN = 32;
  localparam int SW   = 6;
  localparam int NW   = 4;
  localparam int NS   = 64;
`ifdef CPU_BTB_COUNTER_EN
  localparam bit CTR_ON = 1'b1;
`else
  localparam bit CTR_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, update, update_taken;
  logic [XLEN-1:0] update_addr, update_target_addr, branch_addr;
  logic            branch_hit, branch_taken;
  logic [XLEN-1:0] branch_target_addr;

  always #5 clk = ~clk;

  cpu_btb_set_assoc #(.XLEN(XLEN), .SET_WIDTH(SW), .WAYS(NW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .update            (update),
    .update_addr       (update_addr),
    .update_target_addr(update_target_addr),
    .update_taken      (update_taken),
    .branch_addr       (branch_addr),
    .branch_hit        (branch_hit),
    .branch_taken      (branch_taken),
    .branch_target_addr(branch_target_addr)
  );

  // ---------------- scoreboard ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [33:0] exp_q[$];
  string       name_q[$];
  logic [33:0] mon_exp;
  string       mon_name;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Compare {hit, taken, target} half a cycle after each queued lookup.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      check_val(mon_name, {30'b0, branch_hit, branch_taken, branch_target_addr}, {30'b0, mon_exp});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic lk, input logic [31:0] lk_addr, input logic [33:0] lk_exp,
                             input string name, input logic up, input logic [31:0] ua,
                             input logic [31:0] ut, input logic uk, input logic fl);
    @(posedge clk);
    #1;
    branch_addr        = lk_addr;
    update             = up;
    update_addr        = ua;
    update_target_addr = ut;
    update_taken       = uk;
    flush              = fl;
    if (lk) begin
      exp_q.push_back(lk_exp);
      name_q.push_back(name);
    end
  endtask

  task automatic lookup(input logic [31:0] a, input logic h, input logic tk,
                        input logic [31:0] tg, input string n);
    drive_cycle(1'b1, a, {h, tk, tg}, n, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] tg, input logic tk);
    drive_cycle(1'b0, branch_addr, 34'h0, "", 1'b1, a, tg, tk, 1'b0);
  endtask

  task automatic idle();
    drive_cycle(1'b0, branch_addr, 34'h0, "", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [NS][NW];
  logic [23:0] m_tag   [NS][NW];
  logic [31:0] m_tgt   [NS][NW];
  int          m_rr    [NS];
`ifdef CPU_BTB_COUNTER_EN
  logic [1:0]  m_ctr   [NS][NW];
`endif

  function automatic void m_reset();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
`ifdef CPU_BTB_COUNTER_EN
        m_ctr[s][w] = 2'd1;
`endif
      end
    end
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic logic [33:0] m_lookup(input logic [31:0] a);
    int   s;
    logic tk;
    s = int'(a[7:2]);
    for (int w = 0; w < NW; w++) begin
      if (m_valid[s][w] && (m_tag[s][w] == a[31:8])) begin
`ifdef CPU_BTB_COUNTER_EN
        tk = m_ctr[s][w][1];
`else
        tk = 1'b1;
`endif
        return {1'b1, tk, m_tgt[s][w]};
      end
    end
    return 34'h0;
  endfunction

  function automatic void m_update(input logic [31:0] a, input logic [31:0] tg, input logic tk);
    int s, hw, v;
    s  = int'(a[7:2]);
    hw = -1;
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && (m_tag[s][w] == a[31:8])) hw = w;
    if (hw >= 0) begin
      m_tgt[s][hw] = tg;
`ifdef CPU_BTB_COUNTER_EN
      if (tk && m_ctr[s][hw] != 2'd3) m_ctr[s][hw] = m_ctr[s][hw] + 2'd1;
      else if (!tk && m_ctr[s][hw] != 2'd0) m_ctr[s][hw] = m_ctr[s][hw] - 2'd1;
`endif
    end else if (tk) begin
      v = -1;
      for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) begin
        v       = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % NW;
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = a[31:8];
      m_tgt[s][v]   = tg;
`ifdef CPU_BTB_COUNTER_EN
      m_ctr[s][v]   = 2'd2;
`endif
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [23:0] t;
    logic [5:0]  s;
    logic [1:0]  lo;
    t  = 24'($urandom_range(0, 5));
    s  = 6'($urandom_range(0, 1));
    lo = 2'($urandom_range(0, 3));
    return {t, s, lo};
  endfunction

  function automatic logic [31:0] rr_addr(input int t);
    return 32'((t << 8) | (5 << 2));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] la, ua, ut;
    logic        up, uk, fl;

    rst_n = 1'b0; flush = 1'b0; update = 1'b0; update_taken = 1'b0;
    update_addr = '0; update_target_addr = '0; branch_addr = '0;
    repeat (2) @(posedge clk);

    // Outputs held quiet during reset, and a clean miss afterwards.
    lookup(32'h0000_1000, 1'b0, 1'b0, 32'h0, "rst_lookup");
    @(posedge clk); #1 rst_n = 1'b1;
    lookup(32'h0000_1000, 1'b0, 1'b0, 32'h0, "post_rst_miss");

    // Install and read back; not-taken training.
    upd(32'h0000_1000, 32'h0000_2000, 1'b1);
    lookup(32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, "install");
`ifdef CPU_BTB_COUNTER_EN
    upd(32'h0000_1000, 32'h0000_2000, 1'b0);
    upd(32'h0000_1000, 32'h0000_2000, 1'b0);
    lookup(32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000, "two_nt");
`else
    upd(32'h0000_1000, 32'h0000_2000, 1'b0);
    lookup(32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, "nt_no_ctr");
`endif
    upd(32'h0000_1000, 32'h0000_2400, 1'b1);
    lookup(32'h0000_1000, 1'b1, !CTR_ON, 32'h0000_2400, "retarget");
    upd(32'h0000_1100, 32'h0000_5000, 1'b0);
    lookup(32'h0000_1100, 1'b0, 1'b0, 32'h0, "nt_no_alloc");

`ifdef CPU_BTB_COUNTER_EN
    // Counter saturation at both ends.
    upd(32'h0000_3000, 32'h0000_3300, 1'b1);
    upd(32'h0000_3000, 32'h0000_3300, 1'b1);
    lookup(32'h0000_3000, 1'b1, 1'b1, 32'h0000_3300, "ctr_at3");
    for (int i = 0; i < 4; i++) begin
      upd(32'h0000_3000, 32'h0000_3300, 1'b1);
      lookup(32'h0000_3000, 1'b1, 1'b1, 32'h0000_3300, "sat_hi");
    end
    upd(32'h0000_3000, 32'h0000_3300, 1'b0);
    lookup(32'h0000_3000, 1'b1, 1'b1, 32'h0000_3300, "nt_from3");
    upd(32'h0000_3000, 32'h0000_3300, 1'b0);
    upd(32'h0000_3000, 32'h0000_3300, 1'b0);
    lookup(32'h0000_3000, 1'b1, 1'b0, 32'h0000_3300, "at0");
    upd(32'h0000_3000, 32'h0000_3300, 1'b0);
    lookup(32'h0000_3000, 1'b1, 1'b0, 32'h0000_3300, "sat_lo");
    upd(32'h0000_3000, 32'h0000_3300, 1'b1);
    upd(32'h0000_3000, 32'h0000_3300, 1'b1);
    lookup(32'h0000_3000, 1'b1, 1'b1, 32'h0000_3300, "rise");
`endif

    // Five taken allocations into set 5: first is evicted, pointer moves to 1.
    for (int t = 1; t <= 5; t++) upd(rr_addr(t), 32'h8000 + 32'(t * 16), 1'b1);
    lookup(rr_addr(1), 1'b0, 1'b0, 32'h0, "rr_evicted1");
    for (int t = 2; t <= 5; t++) lookup(rr_addr(t), 1'b1, 1'b1, 32'h8000 + 32'(t * 16), "rr_hit");
    upd(rr_addr(6), 32'h8060, 1'b1);
    lookup(rr_addr(2), 1'b0, 1'b0, 32'h0, "rr_evicted2");
    for (int t = 3; t <= 6; t++) lookup(rr_addr(t), 1'b1, 1'b1, 32'h8000 + 32'(t * 16), "rr_hit2");

    // Same-cycle lookup and update to the same entry sees the old contents.
    drive_cycle(1'b1, rr_addr(6), {1'b1, 1'b1, 32'h8060}, "same_set_old",
                1'b1, rr_addr(6), 32'h0000_9990, 1'b1, 1'b0);
    lookup(rr_addr(6), 1'b1, 1'b1, 32'h0000_9990, "same_set_new");

    // Flush beats a simultaneous update.
    drive_cycle(1'b0, branch_addr, 34'h0, "", 1'b1, 32'h0000_4000, 32'h0000_4400, 1'b1, 1'b1);
    lookup(32'h0000_1000, 1'b0, 1'b0, 32'h0, "flush_a");
    lookup(32'h0000_4000, 1'b0, 1'b0, 32'h0, "flush_upd");
    lookup(rr_addr(6), 1'b0, 1'b0, 32'h0, "flush_b");

    // Asynchronous reset clears entries without a clock edge.
    upd(32'h0000_1000, 32'h0000_2000, 1'b1);
    lookup(32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, "pre_arst");
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    branch_addr = 32'h0000_1000;
    exp_q.push_back(34'h0);
    name_q.push_back("arst");
    @(posedge clk); #1 rst_n = 1'b1;
    lookup(32'h0000_1000, 1'b0, 1'b0, 32'h0, "arst_after");

    // Randomized traffic on two sets with six tags against the model.
    m_reset();
    for (int i = 0; i < 400; i++) begin
      la = rand_addr();
      ua = rand_addr();
      ut = $urandom();
      uk = 1'($urandom_range(0, 1));
      up = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      drive_cycle(1'b1, la, m_lookup(la), "rand", up, ua, ut, uk, fl);
      if (fl) m_flush();
      else if (up) m_update(ua, ut, uk);
    end
    idle();

    repeat (2) @(posedge clk);
    check_val("drain", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_btb_set_assoc.md
CPU_BTB_SET_ASSOC -- requirements
Module: cpu_btb_set_assoc

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/target width.
REQ-002 SHALL have parameter SET_WIDTH, default 6, log2 of set count.
REQ-003 SHALL have parameter WAYS, default 4, associativity; legal values 1, 2, 4, 8.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port flush, input, 1, invalidate all entries.
REQ-007 SHALL have port update, input, 1, resolved-branch write strobe.
REQ-008 SHALL have port update_addr, input, XLEN, resolved branch PC.
REQ-009 SHALL have port update_target_addr, input, XLEN, resolved target.
REQ-010 SHALL have port update_taken, input, 1, resolved direction.
REQ-011 SHALL have port branch_addr, input, XLEN, lookup PC.
REQ-012 SHALL have port branch_hit, output, 1, tag match in a valid way.
REQ-013 SHALL have port branch_taken, output, 1, predicted direction.
REQ-014 SHALL have port branch_target_addr, output, XLEN, target of hitting way.

Function
REQ-015 SHALL decompose addresses as: bits [1:0] ignored, set = addr[SET_WIDTH+1:2], tag = addr[XLEN-1:SET_WIDTH+2].
REQ-016 SHALL produce lookup outputs combinationally from branch_addr and current state (zero-cycle latency).
REQ-017 SHALL drive branch_target_addr to all zeros and branch_taken low when branch_hit is low.
REQ-018 SHALL, on update hitting way w, rewrite target of w and step its 2-bit counter: +1 if taken, -1 if not, saturating at 0 and 3.
REQ-019 SHALL, on update missing with update_taken=1, allocate: lowest-index invalid way; else the set's round-robin victim; write tag and target, set valid, counter = 2 (weakly taken).
REQ-020 SHALL not allocate on update missing with update_taken=0.
REQ-021 SHALL keep one log2(WAYS)-bit round-robin pointer per set, advanced (mod WAYS, wraps WAYS-1 -> 0) only when a valid victim is evicted.
REQ-022 SHALL give flush priority over update in the same cycle; update is dropped.
REQ-023 SHALL clear all valid bits in the cycle after flush; counters and pointers are retained.
REQ-024 SHALL return pre-update contents when lookup and update address the same set in the same cycle.
REQ-025 SHALL never hold two valid ways with equal tags in one set.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all valid bits, set counters to 1, and zero round-robin pointers.
REQ-027 SHALL not reset tag or target storage.
REQ-028 SHALL drive branch_hit=0, branch_taken=0, branch_target_addr=0 while in reset.

Configuration
REQ-029 SHALL honour macro CPU_BTB_COUNTER_EN: defined -> counters present, branch_taken = branch_hit & counter[1].
REQ-030 SHALL, without CPU_BTB_COUNTER_EN, omit counters, set branch_taken = branch_hit, and still allocate only on taken updates.

Structure
REQ-031 SHALL place counter width, counter constants (STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3) and saturating-step function in package cpu_btb_pkg.
REQ-032 SHALL implement one sub-module cpu_btb_way (tag/target/valid/counter array of one way, per-set write enable), instantiated WAYS times.

Verification
REQ-033 SHALL check: reset, lookup 0x0000_1000 -> hit=0, taken=0, target=0.
REQ-034 SHALL check: update 0x1000->0x2000 taken; next cycle lookup 0x1000 -> hit=1, target=0x2000, taken=1; 0x1000 not-taken twice -> taken=0, hit=1.
REQ-035 SHALL check: WAYS=4, five taken updates with same set, distinct tags -> first tag misses, tags 2-5 hit, pointer=1.
REQ-036 SHALL check: flush and update asserted together -> next cycle all lookups miss, update not installed.
REQ-037 SHALL check: counter at 3, four further taken updates -> stays 3; at 0, not-taken -> stays 0.
REQ-038 SHALL check: without CPU_BTB_COUNTER_EN, not-taken update to hitting entry -> taken remains 1.
